decrypt: RTL

//  LWE decryption engine; the receive-side counterpart of the encrypt block.

---
 rtl/decrypt.sv | 106 ++++++++++
 1 files changed

// File: rtl/decrypt.sv
// LWE decryption: streams N (a_i, s_i) beats plus b, emits round((b - <a,s>) mod q) mod p.
// b accepted -> DECODE -> pt_valid in OUT; in_ready low outside ACCUM, plaintext held until pt_ready.
module decrypt #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 10,
  parameter int DIM_WIDTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct_elem,
  input  logic [CIPHERTEXT_WIDTH-1:0] sk_elem,
  output logic                        pt_valid,
  input  logic                        pt_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  plaintext
);

  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int PW    = PLAINTEXT_WIDTH;
  localparam int SHIFT = CW - PW;
  localparam logic [CW-1:0] OFFSET = CW'(CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS));

  typedef enum logic [1:0] {S_ACCUM, S_DECODE, S_OUT} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_acc;
  logic [CW-1:0]        r_diff;
  logic [DIM_WIDTH-1:0] r_beat;
  logic                 r_pt_valid;
  logic [PW-1:0]        r_plaintext;

  logic                 w_accept;
  logic                 w_last;
  logic [CW-1:0]        w_prod_lo;

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_beat == DIM_WIDTH'(DIMENSION));
  // Only the low CW bits of the full product survive the mod-q reduction.
  assign w_prod_lo = ct_elem * sk_elem;

  assign pt_valid  = r_pt_valid;
  assign plaintext = r_plaintext;

  always_comb begin
    w_next_state = r_state;
    in_ready     = (r_state == S_ACCUM);
    case (r_state)
      S_ACCUM:  if (w_accept && w_last) w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_OUT;
      S_OUT:    if (pt_ready) w_next_state = S_ACCUM;
      default:  w_next_state = S_ACCUM;
    endcase
    if (clear) w_next_state = S_ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_beat      <= '0;
      r_diff      <= '0;
      r_pt_valid  <= 1'b0;
      r_plaintext <= '0;
    end else begin
      r_state <= w_next_state;
      if (clear) begin
        r_acc      <= '0;
        r_beat     <= '0;
        r_pt_valid <= 1'b0;
      end else begin
        case (r_state)
          S_ACCUM: begin
            if (w_accept) begin
              if (!w_last) begin
                r_acc  <= r_acc + w_prod_lo;
                r_beat <= r_beat + 1'b1;
              end else begin
                r_diff <= ct_elem - r_acc;
              end
            end
          end
          S_DECODE: begin
            // Rounding add wraps mod q so values just below q decode to 0.
            r_plaintext <= PW'(CW'(r_diff + OFFSET) >> SHIFT);
            r_pt_valid  <= 1'b1;
          end
          S_OUT: begin
            if (pt_ready) begin
              r_pt_valid <= 1'b0;
              r_acc      <= '0;
              r_beat     <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
